sized_data_memory: RTL

- Byte-addressable, big-endian MIPS data memory with a request/response handshake.
- Supports byte, halfword and word accesses (LB/LBU/LH/LHU/LW/SB/SH/SW), with sign or zero extension on loads.
- Detects misaligned and out-of-range accesses as faults.
- Has a parametrised read latency, so it can replace the single-cycle word memory in the multi-cycle and pipelined datapath iterations.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/load_align.sv | 44 ++++
 rtl/sized_data_memory.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the sized data memory.
//   - req_size encodings (byte / halfword / word / reserved)
//   - FSM state type used by the top level and exposed on its debug port
//   - MAX_READ_LATENCY and the width of the read-latency counter
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int MAX_READ_LATENCY = 4;

  // The counter is loaded with READ_LATENCY-2, so it never exceeds
  // MAX_READ_LATENCY-2 = 2 and two bits are enough.
  localparam int LAT_CNT_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/load_align.sv
// load_align: combinational load formatter.
//   word        in  32  the aligned word, big-endian: byte at offset 0 is [31:24]
//   offset      in  2   address[1:0] of the access
//   size        in  2   SIZE_BYTE / SIZE_HALF / SIZE_WORD (others give 0)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend (byte/halfword only)
//   data        out 32  extended, right-justified load result
// Misaligned offsets are not rejected here; the caller discards faulting loads.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h00;
    case (offset)
      2'd0:    sel_byte = word[31:24];
      2'd1:    sel_byte = word[23:16];
      2'd2:    sel_byte = word[15:8];
      default: sel_byte = word[7:0];
    endcase

    // Halfwords live at offset 0 (upper half) or offset 2 (lower half).
    sel_half = offset[1] ? word[15:0] : word[31:16];

    data = 32'h0;
    case (size)
      SIZE_BYTE: data = is_unsigned ? {24'h0, sel_byte}
                                    : {{24{sel_byte[7]}}, sel_byte};
      SIZE_HALF: data = is_unsigned ? {16'h0, sel_half}
                                    : {{16{sel_half[15]}}, sel_half};
      SIZE_WORD: data = word;
      default:   data = 32'h0;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// sized_data_memory: byte-addressable, big-endian data memory with byte,
// halfword and word loads/stores, fault detection and a configurable read
// latency (READ_LATENCY in 1..MAX_READ_LATENCY).
//
// Ports:
//   clock        in  1   rising-edge clock
//   reset        in  1   synchronous, active-high
//   req_valid    in  1   request present
//   req_ready    out 1   request can be accepted this cycle
//   req_write    in  1   1 = store, 0 = load
//   req_size     in  2   00 byte, 01 halfword, 10 word, 11 reserved (fault)
//   req_unsigned in  1   loads: 1 = zero-extend, 0 = sign-extend
//   address      in  32  byte address
//   write_data   in  32  right-justified store data
//   resp_valid   out 1   one-cycle response strobe per accepted request
//   read_data    out 32  load result; 0 for stores, faults and idle cycles
//   fault        out 1   qualifies resp_valid: misaligned / out of range / bad size
//   debug_state  out     current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// are both high; request fields must be stable while req_valid is high. Exactly
// one resp_valid pulse follows every transfer (unless reset intervenes), and
// only one request is ever outstanding: req_ready is low while a load waits.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        fault,
  output state_e      debug_state
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [LAT_CNT_BITS-1:0] LAT_LOAD = LAT_CNT_BITS'(READ_LATENCY - 2);

  // Byte array; intentionally not cleared by reset.
  logic [7:0] mem [DEPTH];

  logic [ADDR_BITS-3:0] word_addr;
  logic [1:0]           offset;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 bad_size;
  logic                 req_fault;
  logic                 accept;
  logic                 do_store;
  logic                 is_load_ok;

  logic [31:0]          cur_word;
  logic [31:0]          aligned;
  logic [3:0]           byte_en;
  logic [3:0][7:0]      lane_data;

  state_e                  state, state_next;
  logic [LAT_CNT_BITS-1:0] lat_cnt, cnt_next;
  logic [31:0]             data_q;
  logic                    fault_q;

  assign word_addr = address[ADDR_BITS-1:2];
  assign offset    = address[1:0];

  // ---------------- fault detection ----------------
  assign misaligned   = ((req_size == SIZE_HALF) && offset[0]) ||
                        ((req_size == SIZE_WORD) && (offset != 2'b00));
  assign out_of_range = |address[31:ADDR_BITS];
  assign bad_size     = (req_size == SIZE_RSVD);
  assign req_fault    = misaligned || out_of_range || bad_size;

  assign accept     = req_valid && req_ready;
  assign is_load_ok = !req_write && !req_fault;
  // Reset wins over a store presented on the same edge.
  assign do_store   = accept && req_write && !req_fault && !reset;

  // ---------------- load path ----------------
  assign cur_word = {mem[{word_addr, 2'd0}], mem[{word_addr, 2'd1}],
                     mem[{word_addr, 2'd2}], mem[{word_addr, 2'd3}]};

  load_align u_load_align (
    .word        (cur_word),
    .offset      (offset),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .data        (aligned)
  );

  // ---------------- store byte enables ----------------
  // Lane k is the byte at word base + k, i.e. big-endian bits [31-8k -: 8].
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = '0;
    case (req_size)
      SIZE_BYTE: begin
        byte_en[offset]   = 1'b1;
        lane_data[offset] = write_data[7:0];
      end
      SIZE_HALF: begin
        byte_en[{offset[1], 1'b0}]   = 1'b1;
        byte_en[{offset[1], 1'b1}]   = 1'b1;
        lane_data[{offset[1], 1'b0}] = write_data[15:8];
        lane_data[{offset[1], 1'b1}] = write_data[7:0];
      end
      SIZE_WORD: begin
        byte_en   = 4'b1111;
        lane_data = {write_data[7:0], write_data[15:8],
                     write_data[23:16], write_data[31:24]};
      end
      default: begin
        byte_en   = 4'b0000;
        lane_data = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_store) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem[{word_addr, 2'(k)}] <= lane_data[k];
        end
      end
    end
  end

  // ---------------- response data register ----------------
  // Load data is captured on the accept edge so later stores cannot change it.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      data_q  <= is_load_ok ? aligned : 32'h0;
      fault_q <= req_fault;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= cnt_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    cnt_next   = lat_cnt;
    case (state)
      IDLE, RESP: begin
        // req_ready is high here, so req_valid means the request is accepted.
        state_next = IDLE;
        if (req_valid) begin
          if (is_load_ok && (READ_LATENCY > 1)) begin
            state_next = WAIT;
            cnt_next   = LAT_LOAD;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          state_next = RESP;
        end else begin
          cnt_next = lat_cnt - LAT_CNT_BITS'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready   = (state != WAIT);
    resp_valid  = (state == RESP);
    read_data   = (state == RESP) ? data_q : 32'h0;
    fault       = (state == RESP) ? fault_q : 1'b0;
    debug_state = state;
  end

endmodule
